univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//  Parametrised universal register: successor to the single-bit D latch with set/reset.
//  Edge-triggered WIDTH-bit store with parallel load, shift/rotate in both directions,
//  synchronous preset/clear and a shift counter that flags a full-word shift.
//  Serial/parallel converter and general state register for the lab datapath blocks.
// PARAMETERS
//  WIDTH      8       register width in bits; legal range >= 2
//  RESET_VAL  8'h00   value loaded into q by async reset; WIDTH bits wide
// PORTS
//  clk      in   1      rising-edge clock
//  reset_n  in   1      asynchronous active-low reset
//  set_n    in   1      synchronous active-low preset (q <= all ones)
//  en       in   1      operation enable; 0 = hold
//  mode     in   3      operation select (see BEHAVIOUR)
//  d        in   WIDTH  parallel load data
//  sin_r    in   1      serial in for shift-right (enters MSB)
//  sin_l    in   1      serial in for shift-left (enters LSB)
//  q        out  WIDTH  register contents
//  q_n      out  WIDTH  ~q, always the exact complement of q
//  sout_r   out  1      q[0] (combinational from q)
//  sout_l   out  1      q[WIDTH-1] (combinational from q)
//  done     out  1      one-cycle pulse: WIDTH shift/rotate ops completed
// BEHAVIOUR
//  Reset (reset_n=0, asynchronous, no clock needed):
//   - q=RESET_VAL, q_n=~RESET_VAL, cnt=0, done=0.
//   - Held while low; ops resume on first rising edge after release.
//  Priority at each rising edge: set_n=0 > en=0 > mode.
//  set_n=0: q <= {WIDTH{1'b1}}, cnt <= 0; en and mode ignored.
//  en=0: q and cnt hold.
//  mode encoding, applied when en=1:
//   000 hold.
//   001 SHR: q <= {sin_r, q[W-1:1]}.
//   010 SHL: q <= {q[W-2:0], sin_l}.
//   011 LOAD: q <= d.
//   100 ROR: q <= {q[0], q[W-1:1]}.
//   101 ROL: q <= {q[W-2:0], q[W-1]}.
//   110 CLR: q <= 0.
//   111 reserved, behaves as hold.
//  All q updates take effect one edge after the inputs are sampled (latency 1).
//  Shift counter cnt, width $clog2(WIDTH+1), internal:
//   - +1 on each SHR/SHL/ROR/ROL edge with en=1 and set_n=1.
//   - Cleared by LOAD, CLR, set_n=0 or reset.
//   - Holds on hold/reserved/en=0, so pauses do not break a word.
//   - On the edge where cnt would reach WIDTH: cnt <= 0 and done <= 1.
//  done: registered; high exactly one cycle after that edge; 0 on every other edge.
//  Mixed directions all count (e.g. 4 SHR + 4 SHL with WIDTH=8 gives done).
//  Reset asserted mid-sequence aborts the word: cnt=0, no done pulse.
// TESTING (WIDTH=8, RESET_VAL=8'h00)
//  1 reset_n=0 between edges after q=5A -> q=00, q_n=FF, done=0 immediately,
//    with no clock edge.
//  2 en=1 mode=011 d=A5 -> q=A5; then en=0 mode=011 d=FF for 3 edges -> q stays A5.
//  3 from A5: SHR sin_r=1 -> D2; reload A5, ROL -> 4B; reload A5, ROR -> D2;
//    reload A5, SHL sin_l=0 -> 4A.
//  4 load 81, 8 SHL edges with en=0 gap after the 3rd ->
//    done=1 for exactly one cycle after the 8th shift; q=00.
//  5 set_n=0 with en=1 mode=011 d=3C -> q=FF, cnt cleared;
//    then 7 shifts -> no done.
//  6 5 SHR edges, reset_n pulsed low, 3 SHR edges -> no done;
//    5 more SHR (8 total since reset) -> done pulse.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: parallel load, shift/rotate both ways, sync preset/clear,
// and a shift counter that pulses done once a full word has been shifted.
module univ_shift_reg #(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             set_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             sout_r,
    output logic             sout_l,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_SHR  = 3'b001,
        M_SHL  = 3'b010,
        M_LOAD = 3'b011,
        M_ROR  = 3'b100,
        M_ROL  = 3'b101,
        M_CLR  = 3'b110,
        M_RSVD = 3'b111
    } mode_e;

    mode_e          mode_s;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             shift_op;

    assign mode_s = mode_e'(mode);

    always_comb begin
        q_d      = q_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        shift_op = 1'b0;
        if (!set_n) begin
            q_d   = '1;
            cnt_d = '0;
        end else if (en) begin
            case (mode_s)
                M_SHR: begin
                    q_d      = {sin_r, q_q[WIDTH-1:1]};
                    shift_op = 1'b1;
                end
                M_SHL: begin
                    q_d      = {q_q[WIDTH-2:0], sin_l};
                    shift_op = 1'b1;
                end
                M_ROR: begin
                    q_d      = {q_q[0], q_q[WIDTH-1:1]};
                    shift_op = 1'b1;
                end
                M_ROL: begin
                    q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    shift_op = 1'b1;
                end
                M_LOAD: begin
                    q_d   = d;
                    cnt_d = '0;
                end
                M_CLR: begin
                    q_d   = '0;
                    cnt_d = '0;
                end
                M_HOLD, M_RSVD: ;
                default: ;
            endcase
            // Counter wraps on the word boundary instead of ever holding WIDTH.
            if (shift_op) begin
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q    <= RESET_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q      = q_q;
    assign q_n    = ~q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];
    assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, RESET_VAL=0): vector table, directed
// multi-cycle sequences and randomized stimulus against an arithmetic reference model.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       set_n;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] q;
    logic [7:0] q_n;
    logic       sout_r;
    logic       sout_l;
    logic       done;

    int checks = 0;
    int errors = 0;

    int unsigned mq;
    int unsigned mshifts;
    bit          mdone;

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .set_n  (set_n),
        .en     (en),
        .mode   (mode),
        .d      (d),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .q      (q),
        .q_n    (q_n),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       s;
        logic       e;
        logic [2:0] m;
        logic [7:0] dd;
        logic       sr;
        logic       sl;
        logic [7:0] exp_q;
        logic       exp_done;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq      = 0;
        mshifts = 0;
        mdone   = 0;
    endtask

    // Behavioural model: q as an integer 0..255, shifts as arithmetic.
    task automatic model_edge(input logic s, input logic e, input logic [2:0] m,
                              input logic [7:0] dd, input logic sr, input logic sl);
        bit shifted = 0;
        mdone = 0;
        if (!s) begin
            mq      = 255;
            mshifts = 0;
        end else if (e) begin
            case (m)
                3'd1: begin mq = (mq / 2) + (sr ? 128 : 0);         shifted = 1; end
                3'd2: begin mq = ((mq * 2) % 256) + (sl ? 1 : 0);   shifted = 1; end
                3'd3: begin mq = int'(dd);                          mshifts = 0; end
                3'd4: begin mq = (mq / 2) + ((mq % 2) * 128);       shifted = 1; end
                3'd5: begin mq = ((mq * 2) % 256) + (mq / 128);     shifted = 1; end
                3'd6: begin mq = 0;                                 mshifts = 0; end
                default: ;
            endcase
            if (shifted) begin
                mshifts++;
                if (mshifts == 8) begin
                    mdone   = 1;
                    mshifts = 0;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".q"},      32'(q),      mq);
        chk({tag, ".q_n"},    32'(q_n),    32'(8'(~mq)));
        chk({tag, ".done"},   32'(done),   32'(mdone));
        chk({tag, ".sout_r"}, 32'(sout_r), mq % 2);
        chk({tag, ".sout_l"}, 32'(sout_l), mq / 128);
    endtask

    // Called shortly after a rising edge; returns #1 after the next one.
    task automatic step(input string tag, input logic s, input logic e, input logic [2:0] m,
                        input logic [7:0] dd, input logic sr, input logic sl);
        set_n = s; en = e; mode = m; d = dd; sin_r = sr; sin_l = sl;
        model_edge(s, e, m, dd, sr, sl);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        #2;
        model_reset();
        chk({tag, ".rst_q"},    32'(q),    32'h00);
        chk({tag, ".rst_qn"},   32'(q_n),  32'hFF);
        chk({tag, ".rst_done"}, 32'(done), 32'h0);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        set_n = 1'b1; en = 1'b1; mode = 3'b011; d = 8'hFF; sin_r = 1'b0; sin_l = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset_hold");
        reset_n = 1'b1;

        // Async reset between edges after q=5A.
        step("load5A", 1'b1, 1'b1, 3'b011, 8'h5A, 1'b0, 1'b0);
        async_reset("t1");
        check_model("t1_after");

        vecs[0]  = '{1'b1, 1'b1, 3'b011, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'b011, 8'hFF, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b011, 8'hFF, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'b011, 8'hFF, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 3'b001, 8'h00, 1'b1, 1'b0, 8'hD2, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 3'b011, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 8'h4B, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 3'b011, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'hD2, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 3'b011, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 3'b010, 8'h00, 1'b0, 1'b0, 8'h4A, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 3'b111, 8'hFF, 1'b1, 1'b1, 8'h4A, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 3'b000, 8'hFF, 1'b1, 1'b1, 8'h4A, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 3'b110, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 3'b011, 8'h3C, 1'b0, 1'b0, 8'hFF, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 3'b011, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0};

        for (int i = 0; i < 16; i++) begin
            step($sformatf("vec%0d", i), vecs[i].s, vecs[i].e, vecs[i].m,
                 vecs[i].dd, vecs[i].sr, vecs[i].sl);
            chk($sformatf("vec%0d.tq", i), 32'(q), 32'(vecs[i].exp_q));
            chk($sformatf("vec%0d.tdone", i), 32'(done), 32'(vecs[i].exp_done));
        end

        // 8 SHL from 81 with a one-edge en=0 gap after the third shift.
        step("t4_load", 1'b1, 1'b1, 3'b011, 8'h81, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) step("t4_gap", 1'b1, 1'b0, 3'b010, 8'h00, 1'b0, 1'b0);
            step($sformatf("t4_shl%0d", i), 1'b1, 1'b1, 3'b010, 8'h00, 1'b0, 1'b0);
        end
        chk("t4_done", 32'(done), 32'h1);
        chk("t4_q", 32'(q), 32'h00);
        step("t4_after", 1'b1, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0);
        chk("t4_done_drop", 32'(done), 32'h0);

        // Preset overrides load and clears the counter mid-word.
        step("t5_pre1", 1'b1, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
        step("t5_pre2", 1'b1, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
        step("t5_set", 1'b0, 1'b1, 3'b011, 8'h3C, 1'b0, 1'b0);
        chk("t5_q", 32'(q), 32'hFF);
        for (int i = 0; i < 7; i++) begin
            step($sformatf("t5_sh%0d", i), 1'b1, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
            chk($sformatf("t5_nodone%0d", i), 32'(done), 32'h0);
        end
        step("t5_sh7", 1'b1, 1'b1, 3'b001, 8'h00, 1'b1, 1'b0);
        chk("t5_done8", 32'(done), 32'h1);

        // Reset aborts a partial word.
        for (int i = 0; i < 5; i++)
            step($sformatf("t6_a%0d", i), 1'b1, 1'b1, 3'b001, 8'h00, 1'b1, 1'b0);
        async_reset("t6");
        for (int i = 0; i < 3; i++) begin
            step($sformatf("t6_b%0d", i), 1'b1, 1'b1, 3'b001, 8'h00, 1'b1, 1'b0);
            chk($sformatf("t6_nodone%0d", i), 32'(done), 32'h0);
        end
        for (int i = 0; i < 5; i++)
            step($sformatf("t6_c%0d", i), 1'b1, 1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
        chk("t6_done", 32'(done), 32'h1);

        for (int i = 0; i < 600; i++) begin
            logic [2:0] m;
            if ($urandom_range(0, 59) == 0) begin
                async_reset($sformatf("rnd%0d", i));
            end else begin
                if ($urandom_range(0, 3) != 0) begin
                    case ($urandom_range(0, 3))
                        0:       m = 3'b001;
                        1:       m = 3'b010;
                        2:       m = 3'b100;
                        default: m = 3'b101;
                    endcase
                end else begin
                    m = 3'($urandom_range(0, 7));
                end
                step($sformatf("rnd%0d", i), $urandom_range(0, 19) != 0,
                     $urandom_range(0, 7) != 0, m, 8'($urandom),
                     1'($urandom), 1'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
